// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_e;

  // Device commands
  localparam logic [7:0] CMD_RESET            = 8'hFF;
  localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
  localparam logic [7:0] CMD_SET_DEFAULTS     = 8'hF6;

  // Device responses
  localparam logic [7:0] RESP_ACK    = 8'hFA;
  localparam logic [7:0] RESP_BAT_OK = 8'hAA;

  // Odd parity bit: makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status pulses between a requester and ps2_host_tx.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (output tx_valid, tx_data,
                  input  tx_ready, busy, done, ack_err, timeout);
  modport slave  (input  tx_valid, tx_data,
                  output tx_ready, busy, done, ack_err, timeout);
endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus FILTER_LEN-sample debounce for a PS/2 line.
// level idles high; fall/rise are 1-cycle strobes on accepted level changes.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          meta, sync;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      fall <= 1'b0;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync;
        cnt   <= '0;
        fall  <= ~sync;
        rise  <= sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out
// start/8 data/parity/stop on device CLK falls, then check the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  output logic         rx_inhibit
);
  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(INHIBIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic [9:0]    sh;       // {stop, parity, data[7:0]}, LSB goes out next
  logic [3:0]    bitcnt;   // CLK falls seen so far in this frame
  logic          data_meta, data_sync;
  logic          clk_level, clk_fall, clk_rise_unused;
  logic          done_r, ack_err_r, timeout_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .rst   (rst),
    .din   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall),
    .rise  (clk_rise_unused)
  );

  // DATA only needs synchronizing; it is sampled well after it settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // Frame sequencer; cnt is the inhibit timer in INHIBIT and the
  // fall-to-fall watchdog in every later state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sh          <= '0;
      bitcnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done_r      <= 1'b0;
      ack_err_r   <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      timeout_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd.tx_valid) begin
            sh         <= {1'b1, odd_parity(cmd.tx_data), cmd.tx_data};
            cnt        <= '0;
            bitcnt     <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          // Falls here are our own CLK pull-down or device glitches: ignored.
          cnt <= cnt + CW'(1);
          if (cnt >= HALF_M1) ps2_data_oe <= 1'b1;
          if (cnt == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            cnt         <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ, ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
          if (clk_fall) begin
            cnt <= '0;
            case (state)
              ST_REQ, ST_DATA: begin
                // Falls 1..10 put out bit0..bit7, parity, stop (stop releases DATA).
                ps2_data_oe <= ~sh[0];
                sh          <= {1'b0, sh[9:1]};
                bitcnt      <= bitcnt + 4'd1;
                state       <= (bitcnt == 4'd9) ? ST_ACK : ST_DATA;
              end
              ST_ACK: begin
                if (data_sync) begin
                  ack_err_r   <= 1'b1;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  state       <= ST_IDLE;
                end else begin
                  state <= ST_WAIT_IDLE;
                end
              end
              default: ;  // a stray fall while waiting for idle just rearms the watchdog
            endcase
          end else if (state == ST_WAIT_IDLE && clk_level && data_sync) begin
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end else if (cnt == TO_LAST) begin
            timeout_r   <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.tx_ready = (state == ST_IDLE);
  assign cmd.busy     = (state != ST_IDLE);
  assign rx_inhibit   = (state != ST_IDLE);
  assign cmd.done     = done_r;
  assign cmd.ack_err  = ack_err_r;
  assign cmd.timeout  = timeout_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host
// and a scoreboard of expected frames is compared against what it captures.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH    = 200;
  localparam int TMO    = 1500;
  localparam int FLT    = 8;
  localparam int H      = 40;     // device half clock period in clk cycles
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_pin, data_pin, clk_oe, data_oe, rx_inhibit;
  logic bfm_clk_low = 1'b0;
  logic bfm_data_low = 1'b0;

  ps2_host_tx_if cmd_if();

  // Open-drain wired-AND of host and device drivers.
  assign clk_pin  = ~(clk_oe | bfm_clk_low);
  assign data_pin = ~(data_oe | bfm_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .ps2_clk_in  (clk_pin),
    .ps2_data_in (data_pin),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .rx_inhibit  (rx_inhibit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  logic [10:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, exclusivity, width, and state one cycle later.
  int   done_cnt = 0, err_cnt = 0, to_cnt = 0, multi_cnt = 0, long_cnt = 0, to_cyc = 0;
  logic prev_pulse = 1'b0, post_pend = 1'b0;
  logic post_ready = 1'b0, post_clk_oe = 1'b1, post_data_oe = 1'b1;
  logic pulse_any;
  assign pulse_any = cmd_if.done | cmd_if.ack_err | cmd_if.timeout;

  always @(negedge clk) begin
    if (post_pend === 1'b1) begin
      post_ready   <= cmd_if.tx_ready;
      post_clk_oe  <= clk_oe;
      post_data_oe <= data_oe;
    end
    if (cmd_if.done === 1'b1) done_cnt <= done_cnt + 1;
    if (cmd_if.ack_err === 1'b1) err_cnt <= err_cnt + 1;
    if (cmd_if.timeout === 1'b1) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (((cmd_if.done & cmd_if.ack_err) | (cmd_if.done & cmd_if.timeout) |
         (cmd_if.ack_err & cmd_if.timeout)) === 1'b1) multi_cnt <= multi_cnt + 1;
    if (pulse_any === 1'b1 && prev_pulse === 1'b1) long_cnt <= long_cnt + 1;
    post_pend  <= (pulse_any === 1'b1);
    prev_pulse <= (pulse_any === 1'b1);
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (cmd_if.tx_ready !== 1'b1 && n < BUDGET) begin n++; step(); end
    if (n >= BUDGET) begin
      n_cmp++; n_bad++;
      $display("FAIL send_ready: tx_ready=%b required 1", cmd_if.tx_ready);
    end
    cmd_if.tx_valid = 1'b1;
    cmd_if.tx_data  = b;
    sb.push_back(frame_of(b));
    step();
    cmd_if.tx_valid = 1'b0;
    cmd_if.tx_data  = ~b;   // must not be re-sampled
  endtask

  // Device model: checks inhibit/RTS, then clocks nfall falls, sampling DATA
  // after each rise (start bit is sampled before the first fall).
  task automatic bfm_frame(input int nfall, input bit give_ack, output logic [10:0] cap);
    int n;
    logic last_d;
    cap = '0;
    last_d = 1'b0;
    n = 0;
    while (clk_oe !== 1'b1 && n < BUDGET) begin n++; step(); end
    n_cmp++;
    if (clk_oe !== 1'b1 || data_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL inhibit_start: clk_oe=%b data_oe=%b required 1/0", clk_oe, data_oe);
    end
    n = 0;
    while (clk_oe === 1'b1 && n < BUDGET) begin last_d = data_oe; n++; step(); end
    n_cmp++;
    if (n < INH || n > INH + 2) begin
      n_bad++;
      $display("FAIL inhibit_len: got %0d cycles required %0d..%0d", n, INH, INH + 2);
    end
    n_cmp++;
    if (last_d !== 1'b1 || data_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL rts_data: data_oe before/after release=%b/%b required 1/1", last_d, data_oe);
    end
    repeat (H) step();
    cap[0] = data_pin;
    for (int k = 1; k <= nfall; k++) begin
      bfm_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (H) step();
      bfm_clk_low = 1'b0;
      if (k <= 10) cap[k] = data_pin;
      if (k == 10 && give_ack) bfm_data_low = 1'b1;
      if (k == 11) bfm_data_low = 1'b0;
      if (k < nfall) repeat (H) step();
    end
  endtask

  task automatic wait_evt(input int base, input string what);
    int n;
    n = 0;
    while (done_cnt + err_cnt + to_cnt == base && n < 3 * TMO) begin n++; step(); end
    if (n >= 3 * TMO) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_wait: no pulse within %0d cycles", what, n);
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    cmd_if.tx_valid = 1'b1;
    cmd_if.tx_data  = 8'hF4;
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({cmd_if.tx_ready, cmd_if.busy, rx_inhibit, clk_oe, data_oe,
         cmd_if.done, cmd_if.ack_err, cmd_if.timeout} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_state: rdy,busy,inh,coe,doe,done,err,to=%b required 10000000",
               {cmd_if.tx_ready, cmd_if.busy, rx_inhibit, clk_oe, data_oe,
                cmd_if.done, cmd_if.ack_err, cmd_if.timeout});
    end
    cmd_if.tx_valid = 1'b0;
    rst = 1'b0;
    repeat (5) step();
    n_cmp++;
    if ({cmd_if.tx_ready, cmd_if.busy, clk_oe, data_oe} !== 4'b1000) begin
      n_bad++;
      $display("FAIL idle_after_reset: rdy,busy,coe,doe=%b required 1000",
               {cmd_if.tx_ready, cmd_if.busy, clk_oe, data_oe});
    end
  endtask

  task automatic test_frames();
    logic [7:0]  cmds [3];
    logic [10:0] cap, exp;
    int b0, d0, e0, t0;
    cmds = '{CMD_ENABLE_REPORTING, 8'h00, 8'hFF};
    foreach (cmds[i]) begin
      b0 = done_cnt + err_cnt + to_cnt; d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
      send(cmds[i]);
      n_cmp++;
      if ({cmd_if.busy, rx_inhibit, cmd_if.tx_ready} !== 3'b110) begin
        n_bad++;
        $display("FAIL busy_flags_%h: busy,inh,rdy=%b required 110", cmds[i],
                 {cmd_if.busy, rx_inhibit, cmd_if.tx_ready});
      end
      bfm_frame(11, 1'b1, cap);
      wait_evt(b0, "done");
      exp = sb.pop_front();
      n_cmp++;
      if (cap !== exp) begin
        n_bad++;
        $display("FAIL frame_%h: got %b required %b", cmds[i], cap, exp);
      end
      n_cmp++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || to_cnt - t0 !== 0) begin
        n_bad++;
        $display("FAIL pulses_%h: done/err/to deltas %0d/%0d/%0d required 1/0/0", cmds[i],
                 done_cnt - d0, err_cnt - e0, to_cnt - t0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] cap1, cap2, exp;
    int b0, d0, n;
    b0 = done_cnt + err_cnt + to_cnt; d0 = done_cnt;
    send(8'h5A);
    // Held request during frame 1 must wait for IDLE, then go out next.
    cmd_if.tx_valid = 1'b1;
    cmd_if.tx_data  = 8'hA5;
    sb.push_back(frame_of(8'hA5));
    bfm_frame(11, 1'b1, cap1);
    n = 0;
    while (cmd_if.tx_ready !== 1'b1 && n < BUDGET) begin n++; step(); end
    while (cmd_if.busy !== 1'b1 && n < BUDGET) begin n++; step(); end
    cmd_if.tx_valid = 1'b0;
    if (n >= BUDGET) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_accept: busy=%b required 1", cmd_if.busy);
    end
    bfm_frame(11, 1'b1, cap2);
    wait_evt(b0 + 1, "b2b_done");
    exp = sb.pop_front();
    n_cmp++;
    if (cap1 !== exp) begin
      n_bad++;
      $display("FAIL b2b_frame1: got %b required %b", cap1, exp);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (cap2 !== exp) begin
      n_bad++;
      $display("FAIL b2b_frame2: got %b required %b", cap2, exp);
    end
    n_cmp++;
    if (done_cnt - d0 !== 2) begin
      n_bad++;
      $display("FAIL b2b_done: got %0d done pulses required 2", done_cnt - d0);
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] cap, exp;
    int b0, d0, e0;
    b0 = done_cnt + err_cnt + to_cnt; d0 = done_cnt; e0 = err_cnt;
    send(CMD_SET_DEFAULTS);
    bfm_frame(11, 1'b0, cap);
    wait_evt(b0, "ack_err");
    exp = sb.pop_front();
    n_cmp++;
    if (cap !== exp) begin
      n_bad++;
      $display("FAIL noack_frame: got %b required %b", cap, exp);
    end
    n_cmp++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL noack_pulses: err/done deltas %0d/%0d required 1/0", err_cnt - e0, done_cnt - d0);
    end
    n_cmp++;
    if ({post_ready, post_clk_oe, post_data_oe} !== 3'b100) begin
      n_bad++;
      $display("FAIL noack_release: rdy,coe,doe=%b required 100", {post_ready, post_clk_oe, post_data_oe});
    end
  endtask

  task automatic test_timeout();
    logic [10:0] cap, exp;
    int b0, d0, e0, t0, dt;
    b0 = done_cnt + err_cnt + to_cnt; d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
    send(8'hA3);
    bfm_frame(3, 1'b1, cap);
    wait_evt(b0, "timeout");
    exp = sb.pop_front();
    n_cmp++;
    if (cap[3:0] !== exp[3:0]) begin
      n_bad++;
      $display("FAIL to_partial: got %b required %b", cap[3:0], exp[3:0]);
    end
    n_cmp++;
    if (to_cnt - t0 !== 1 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      n_bad++;
      $display("FAIL to_pulses: to/done/err deltas %0d/%0d/%0d required 1/0/0",
               to_cnt - t0, done_cnt - d0, err_cnt - e0);
    end
    dt = to_cyc - last_fall_cyc;
    n_cmp++;
    if (dt < TMO || dt > TMO + FLT + 8) begin
      n_bad++;
      $display("FAIL to_delay: got %0d cycles required %0d..%0d", dt, TMO, TMO + FLT + 8);
    end
    n_cmp++;
    if ({post_ready, post_clk_oe, post_data_oe} !== 3'b100) begin
      n_bad++;
      $display("FAIL to_release: rdy,coe,doe=%b required 100", {post_ready, post_clk_oe, post_data_oe});
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] cap, exp;
    int b0, d0;
    send(8'h3C);
    bfm_frame(4, 1'b1, cap);
    exp = sb.pop_front();
    n_cmp++;
    if (cap[4:0] !== exp[4:0]) begin
      n_bad++;
      $display("FAIL rst_partial: got %b required %b", cap[4:0], exp[4:0]);
    end
    b0 = done_cnt + err_cnt + to_cnt;
    rst = 1'b1;
    step();
    n_cmp++;
    if ({clk_oe, data_oe, cmd_if.tx_ready, cmd_if.busy, rx_inhibit} !== 5'b00100) begin
      n_bad++;
      $display("FAIL rst_mid_state: coe,doe,rdy,busy,inh=%b required 00100",
               {clk_oe, data_oe, cmd_if.tx_ready, cmd_if.busy, rx_inhibit});
    end
    rst = 1'b0;
    repeat (20) step();
    n_cmp++;
    if (done_cnt + err_cnt + to_cnt !== b0 || clk_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: pulses %0d clk_oe=%b required 0/0",
               done_cnt + err_cnt + to_cnt - b0, clk_oe);
    end
    d0 = done_cnt;
    send(CMD_RESET);
    bfm_frame(11, 1'b1, cap);
    wait_evt(b0, "rst_done");
    exp = sb.pop_front();
    n_cmp++;
    if (cap !== exp) begin
      n_bad++;
      $display("FAIL rst_reframe: got %b required %b", cap, exp);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL rst_redone: got %0d done pulses required 1", done_cnt - d0);
    end
  endtask

  task automatic test_pulses();
    n_cmp++;
    if (multi_cnt !== 0 || long_cnt !== 0) begin
      n_bad++;
      $display("FAIL pulse_shape: overlapping=%0d widened=%0d required 0/0", multi_cnt, long_cnt);
    end
  endtask

  initial begin
    cmd_if.tx_valid = 1'b0;
    cmd_if.tx_data  = 8'h00;
    test_reset();
    test_frames();
    test_back_to_back();
    test_no_ack();
    test_timeout();
    test_reset_mid();
    test_pulses();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
